// File: rtl/fwd_pkg.sv
// fwd_pkg: shared select encoding, stall FSM state encoding and constants for fwd_hazard_unit
package fwd_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WBD = 2'b11
  } fwd_sel_t;
  typedef logic [1:0] hz_state_t;
  localparam hz_state_t IDLE      = 2'd0;
  localparam hz_state_t LOAD_WAIT = 2'd1;
  localparam hz_state_t MEM_WAIT  = 2'd2;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: single-operand forwarding priority comparator (MEM > WB > WB-delay > regfile)
module fwd_select import fwd_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wbd_valid_i,
  input  logic [REG_AW-1:0] wbd_rd_i,
  output fwd_sel_t          sel_o
);
  logic mem_hit, wb_hit, wbd_hit;
  assign mem_hit = mem_reg_write_i && mem_rd_i != REG_AW'(REG_ZERO) && mem_rd_i == ex_rs_i;
  assign wb_hit  = wb_reg_write_i && wb_rd_i != REG_AW'(REG_ZERO) && wb_rd_i == ex_rs_i;
  assign wbd_hit = wbd_valid_i && wbd_rd_i == ex_rs_i;
  assign sel_o = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : wbd_hit ? FWD_WBD : FWD_RF;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects plus load-use stall FSM between ID and EX.
// Optional FWD_WB_BYPASS_EN adds a one-entry WB-delay register feeding select 11.
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
  input  logic                      ex_reg_write_i,
  input  logic                      ex_mem_read_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic                      mem_reg_write_i,
  input  logic [REG_AW-1:0]         mem_rd_i,
  input  logic                      mem_busy_i,
  input  logic                      wb_reg_write_i,
  input  logic [REG_AW-1:0]         wb_rd_i,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic                      hazard_o
);
  localparam logic [3:0] CNT_INIT = LOAD_LAT > 1 ? 4'(LOAD_LAT - 2) : 4'd0;
  if (LOAD_LAT < 1 || LOAD_LAT > 15 || NUM_SRC < 1 || NUM_SRC > 4) begin : g_bad_cfg
    $error("fwd_hazard_unit: LOAD_LAT must be 1..15 and NUM_SRC 1..4");
  end
  hz_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0] rs_hit;
  fwd_sel_t sel [NUM_SRC];
  logic hz, wbd_valid;
  logic [REG_AW-1:0] wbd_rd;
`ifdef FWD_WB_BYPASS_EN
  logic wbd_valid_q;
  logic [REG_AW-1:0] wbd_rd_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      wbd_valid_q <= 1'b0;
      wbd_rd_q    <= '0;
    end else begin
      wbd_valid_q <= wb_reg_write_i && wb_rd_i != REG_AW'(REG_ZERO);
      wbd_rd_q    <= wb_rd_i;
    end
  assign wbd_valid = wbd_valid_q;
  assign wbd_rd    = wbd_rd_q;
`else
  assign wbd_valid = 1'b0;
  assign wbd_rd    = '0;
`endif
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign rs_hit[k] = id_rs_used_i[k] && id_rs_i[k*REG_AW +: REG_AW] == ex_rd_i;
    fwd_select #(.REG_AW(REG_AW)) u_sel (
      .ex_rs_i         (ex_rs_i[k*REG_AW +: REG_AW]),
      .mem_reg_write_i (mem_reg_write_i),
      .mem_rd_i        (mem_rd_i),
      .wb_reg_write_i  (wb_reg_write_i),
      .wb_rd_i         (wb_rd_i),
      .wbd_valid_i     (wbd_valid),
      .wbd_rd_i        (wbd_rd),
      .sel_o           (sel[k])
    );
    assign fwd_sel_o[2*k +: 2] = rst_i ? 2'b00 : sel[k];
  end
  assign hz = id_valid_i && ex_mem_read_i && ex_reg_write_i && ex_rd_i != REG_AW'(REG_ZERO) && |rs_hit;
  assign stall_o  = !rst_i && !flush_i && (state_q != IDLE || hz);
  assign bubble_o = stall_o;
  assign hazard_o = !rst_i && !flush_i && state_q == IDLE && hz;
  // hz outside IDLE is deliberately ignored; it is picked up again once back in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE && hz) begin
      state_d = LOAD_LAT > 1 ? LOAD_WAIT : mem_busy_i ? MEM_WAIT : IDLE;
      cnt_d   = CNT_INIT;
    end else if (state_q == LOAD_WAIT) begin
      state_d = cnt_q != 4'd0 ? LOAD_WAIT : mem_busy_i ? MEM_WAIT : IDLE;
      cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    end else if (state_q != IDLE && (state_q != MEM_WAIT || !mem_busy_i)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
endmodule
